// File: rtl/irs3c_reg_receiver_if.sv
// Serial programming bus plus register-file access for the IRS3C register receiver.
// The master drives SIN/SCLK/PCLK and reads back; the slave is the receiver itself.
interface irs3c_reg_receiver_if;
  logic        SIN;
  logic        SCLK;
  logic        PCLK;
  logic        SHOUT;
  logic [5:0]  rd_addr;
  logic [11:0] rd_data;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wilk_start;
  logic        frame_err;
  logic        err_clr;
  logic [7:0]  load_count;

  modport master (
    output SIN, SCLK, PCLK, rd_addr, err_clr,
    input  SHOUT, rd_data, wr_strobe, wr_addr, wr_data, wilk_start, frame_err, load_count
  );

  modport slave (
    input  SIN, SCLK, PCLK, rd_addr, err_clr,
    output SHOUT, rd_data, wr_strobe, wr_addr, wr_data, wilk_start, frame_err, load_count
  );
endinterface

// File: rtl/irs3c_reg_receiver.sv
// IRS3C serial register receiver: 18-bit SIN/SCLK/PCLK word capture, latch/load
// decode, 64x12 register file, SHOUT regeneration and protocol error tracking.
module irs3c_reg_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int START_ADDR  = 61
) (
  input logic             clk,
  input logic             reset,
  irs3c_reg_receiver_if.slave bus
);

  localparam int         NS      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [5:0] START_A = START_ADDR[5:0];

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_SHIFTING = 2'd1,
    ST_LATCHED  = 2'd2
  } state_t;

  logic [NS-1:0] sin_sync_r, sclk_sync_r, pclk_sync_r, fill_r;
  logic          sclk_d_r, pclk_d_r, sclk_arm_r, pclk_arm_r;
  logic          sin_s, sclk_s, pclk_s, fill_done_s, sclk_rise_s, pclk_rise_s;

  state_t        state_r, state_nxt_s;
  logic [4:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [17:0]   sr_r, sr_nxt_s, hold_r, hold_nxt_s;
  logic          err_set_s, load_s, load_pend_r;

  logic [11:0]   regs_r [64];
  logic [11:0]   rd_data_r, wr_data_r;
  logic [5:0]    wr_addr_r;
  logic          wr_strobe_r, wilk_start_r, frame_err_r, shout_r;
  logic [7:0]    load_count_r;

  assign sin_s       = sin_sync_r[NS-1];
  assign sclk_s      = sclk_sync_r[NS-1];
  assign pclk_s      = pclk_sync_r[NS-1];
  assign fill_done_s = fill_r[NS-1];
  // An edge only counts once its line has been seen low after reset.
  assign sclk_rise_s = sclk_arm_r & sclk_s & ~sclk_d_r;
  assign pclk_rise_s = pclk_arm_r & pclk_s & ~pclk_d_r;

  // Input synchronizers, edge-detect delay flops and per-line arming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sin_sync_r  <= '0;
      sclk_sync_r <= '0;
      pclk_sync_r <= '0;
      fill_r      <= '0;
      sclk_d_r    <= 1'b0;
      pclk_d_r    <= 1'b0;
      sclk_arm_r  <= 1'b0;
      pclk_arm_r  <= 1'b0;
    end else begin
      sin_sync_r  <= {sin_sync_r[NS-2:0], bus.SIN};
      sclk_sync_r <= {sclk_sync_r[NS-2:0], bus.SCLK};
      pclk_sync_r <= {pclk_sync_r[NS-2:0], bus.PCLK};
      fill_r      <= {fill_r[NS-2:0], 1'b1};
      sclk_d_r    <= sclk_s;
      pclk_d_r    <= pclk_s;
      sclk_arm_r  <= sclk_arm_r | (fill_done_s & ~sclk_s);
      pclk_arm_r  <= pclk_arm_r | (fill_done_s & ~pclk_s);
    end
  end

  // Word framing state, bit counter, shift and hold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      bit_cnt_r   <= 5'd0;
      sr_r        <= 18'd0;
      hold_r      <= 18'd0;
      load_pend_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      sr_r        <= sr_nxt_s;
      hold_r      <= hold_nxt_s;
      load_pend_r <= load_s;
    end
  end

  // Next-state decode of SCLK shifts and PCLK latch/load phases.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    sr_nxt_s      = sr_r;
    hold_nxt_s    = hold_r;
    err_set_s     = 1'b0;
    load_s        = 1'b0;
    if (sclk_rise_s && pclk_rise_s) begin
      err_set_s = 1'b1;
    end else if (sclk_rise_s) begin
      sr_nxt_s  = {sr_r[16:0], sin_s};
      err_set_s = (bit_cnt_r == 5'd18);
      case (state_r)
        ST_EMPTY: begin
          state_nxt_s   = ST_SHIFTING;
          bit_cnt_nxt_s = 5'd1;
        end
        ST_SHIFTING: begin
          bit_cnt_nxt_s = (bit_cnt_r == 5'd18) ? 5'd18 : bit_cnt_r + 5'd1;
        end
        ST_LATCHED: begin
          err_set_s     = 1'b1;
          state_nxt_s   = ST_SHIFTING;
          bit_cnt_nxt_s = 5'd1;
        end
        default: begin
          state_nxt_s   = ST_EMPTY;
          bit_cnt_nxt_s = 5'd0;
        end
      endcase
    end else if (pclk_rise_s) begin
      case (state_r)
        ST_EMPTY: begin
          err_set_s = sin_s;
        end
        ST_SHIFTING: begin
          if (!sin_s && (bit_cnt_r == 5'd18)) begin
            hold_nxt_s  = sr_r;
            state_nxt_s = ST_LATCHED;
          end else begin
            err_set_s     = 1'b1;
            bit_cnt_nxt_s = 5'd0;
            state_nxt_s   = ST_EMPTY;
          end
        end
        ST_LATCHED: begin
          if (sin_s) begin
            load_s        = 1'b1;
            bit_cnt_nxt_s = 5'd0;
            state_nxt_s   = ST_EMPTY;
          end else begin
            hold_nxt_s = sr_r;
          end
        end
        default: begin
          state_nxt_s   = ST_EMPTY;
          bit_cnt_nxt_s = 5'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Register file write on a decoded load, plus the load reporting outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        regs_r[i] <= 12'd0;
      end
      wr_strobe_r  <= 1'b0;
      wilk_start_r <= 1'b0;
      wr_addr_r    <= 6'd0;
      wr_data_r    <= 12'd0;
      load_count_r <= 8'd0;
    end else if (load_pend_r) begin
      regs_r[hold_r[17:12]] <= hold_r[11:0];
      wr_strobe_r  <= 1'b1;
      wilk_start_r <= (hold_r[17:12] == START_A) && (hold_r[11:0] == 12'hFFF);
      wr_addr_r    <= hold_r[17:12];
      wr_data_r    <= hold_r[11:0];
      load_count_r <= load_count_r + 8'd1;
    end else begin
      wr_strobe_r  <= 1'b0;
      wilk_start_r <= 1'b0;
    end
  end

  // Read port, sticky error flag (set beats clear) and SHOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_r   <= 12'd0;
      frame_err_r <= 1'b0;
      shout_r     <= 1'b0;
    end else begin
      rd_data_r <= regs_r[bus.rd_addr];
      shout_r   <= sr_r[17];
      if (err_set_s) begin
        frame_err_r <= 1'b1;
      end else if (bus.err_clr) begin
        frame_err_r <= 1'b0;
      end else begin
        frame_err_r <= frame_err_r;
      end
    end
  end

  assign bus.SHOUT      = shout_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.wr_strobe  = wr_strobe_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.wilk_start = wilk_start_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.load_count = load_count_r;

endmodule

// File: tb/tb_irs3c_reg_receiver.sv
// Randomized bench for irs3c_reg_receiver against a word-level protocol model.
module tb_irs3c_reg_receiver;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irs3c_reg_receiver_if bus();
  irs3c_reg_receiver #(.SYNC_STAGES(2), .START_ADDR(61)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  typedef struct packed { logic [5:0] addr; logic [11:0] data; logic wilk; } wr_t;

  int errors = 0;
  int checks = 0;

  // protocol model
  int          bits;
  logic        latched;
  logic [17:0] msr, mhold;
  logic        merr;
  int          mcount;
  logic [5:0]  mwaddr;
  logic [11:0] mwdata;
  logic [11:0] mregs [64];
  wr_t         exp_q [$];

  // compare-side state
  logic [11:0] shadow [64];
  logic [11:0] exp_rd;
  logic        prev_strobe;
  int          wilk_seen = 0;
  logic        rd_fix = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    bits = 0; latched = 1'b0; msr = 18'd0; mhold = 18'd0; merr = 1'b0;
    mcount = 0; mwaddr = 6'd0; mwdata = 12'd0;
    for (int i = 0; i < 64; i++) mregs[i] = 12'd0;
    exp_q.delete();
  endtask

  task automatic model_sclk(input logic b);
    if (latched) begin
      merr = 1'b1; latched = 1'b0; bits = 1;
    end else begin
      if (bits == 18) merr = 1'b1;
      bits = (bits < 18) ? bits + 1 : 18;
    end
    msr = {msr[16:0], b};
  endtask

  task automatic model_pclk(input logic s);
    wr_t w;
    if (latched) begin
      if (s) begin
        w.addr = mhold[17:12]; w.data = mhold[11:0];
        w.wilk = (mhold[17:12] == 6'd61) && (mhold[11:0] == 12'hFFF);
        exp_q.push_back(w);
        mregs[w.addr] = w.data; mwaddr = w.addr; mwdata = w.data;
        mcount = mcount + 1; latched = 1'b0; bits = 0;
      end else begin
        mhold = msr;
      end
    end else if (bits == 0) begin
      if (s) merr = 1'b1;
    end else if (!s && bits == 18) begin
      mhold = msr; latched = 1'b1;
    end else begin
      merr = 1'b1; bits = 0;
    end
  endtask

  task automatic sclk_bit(input logic b);
    int ph;
    ph = $urandom_range(3, 8);
    bus.SIN = b;
    wait_cyc(ph);
    check("shout_track", bus.SHOUT, msr[17]);
    bus.SCLK = 1'b1;
    model_sclk(b);
    wait_cyc(ph);
    bus.SCLK = 1'b0;
  endtask

  task automatic pclk_pulse(input logic s);
    int ph;
    ph = $urandom_range(3, 8);
    bus.SIN = s;
    wait_cyc(ph);
    bus.PCLK = 1'b1;
    model_pclk(s);
    wait_cyc(ph);
    bus.PCLK = 1'b0;
  endtask

  task automatic shift_bits(input logic [17:0] w, input int n);
    for (int i = 17; i > 17 - n; i--) sclk_bit(w[i]);
  endtask

  task automatic settle();
    wait_cyc(8);
    check("frame_err", bus.frame_err, merr);
    check("load_count", bus.load_count, mcount[7:0]);
    check("wr_addr_last", bus.wr_addr, mwaddr);
    check("wr_data_last", bus.wr_data, mwdata);
    check("shout_idle", bus.SHOUT, msr[17]);
    check("pending_writes", exp_q.size(), 0);
  endtask

  task automatic full_write(input logic [5:0] a, input logic [11:0] d);
    shift_bits({a, d}, 18);
    pclk_pulse(1'b0);
    pclk_pulse(1'b1);
    settle();
  endtask

  task automatic read_check(input string name, input logic [5:0] a, input logic [11:0] exp);
    rd_fix = 1'b1;
    bus.rd_addr = a;
    wait_cyc(2);
    check(name, bus.rd_data, exp);
    rd_fix = 1'b0;
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    wait_cyc(1);
    bus.err_clr = 1'b0;
    merr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    wait_cyc(4);
    reset = 1'b0;
  endtask

  // random read address whenever the stimulus is not pinning it
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rd_fix) bus.rd_addr = 6'($urandom_range(0, 63));
    end
  end

  // per-cycle compare of read port and load pulses against the model
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) shadow[i] = 12'd0;
      exp_rd = 12'd0;
      prev_strobe = 1'b0;
    end else begin
      check("rd_data", bus.rd_data, exp_rd);
      check("strobe_one_cycle", prev_strobe & bus.wr_strobe, 1'b0);
      if (bus.wilk_start) wilk_seen++;
      if (bus.wr_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", bus.wr_strobe, 1'b0);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("wr_addr", bus.wr_addr, w.addr);
          check("wr_data", bus.wr_data, w.data);
          check("wilk_start", bus.wilk_start, w.wilk);
          shadow[w.addr] = w.data;
        end
      end else begin
        check("wilk_without_strobe", bus.wilk_start, 1'b0);
      end
      prev_strobe = bus.wr_strobe;
      exp_rd = shadow[bus.rd_addr];
    end
  end

  initial begin
    bus.SIN = 1'b0; bus.SCLK = 1'b0; bus.PCLK = 1'b0; bus.err_clr = 1'b0; bus.rd_addr = 6'd0;
    do_reset();
    wait_cyc(2);
    check("rst_shout", bus.SHOUT, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_load_count", bus.load_count, 8'd0);
    check("rst_wr_strobe", bus.wr_strobe, 1'b0);
    check("rst_wr_addr", bus.wr_addr, 6'd0);
    check("rst_wr_data", bus.wr_data, 12'd0);

    // basic write
    full_write(6'd0, 12'hABC);
    check("t1_load_count", bus.load_count, 8'd1);
    check("t1_wr_data", bus.wr_data, 12'hABC);
    check("t1_frame_err", bus.frame_err, 1'b0);
    read_check("t1_rd", 6'd0, 12'hABC);

    // wilk_start only on 0xFFF to START_ADDR
    full_write(6'd61, 12'hFFF);
    check("t2_wilk_once", wilk_seen, 1);
    full_write(6'd61, 12'hFFE);
    check("t2_wilk_still_once", wilk_seen, 1);
    read_check("t2_rd", 6'd61, 12'hFFE);

    // short word then latch
    shift_bits({6'd9, 12'h777}, 17);
    pclk_pulse(1'b0);
    settle();
    check("t3_frame_err_set", bus.frame_err, 1'b1);
    read_check("t3_rd_unchanged", 6'd9, 12'h000);
    clear_err();
    settle();
    check("t3_frame_err_clr", bus.frame_err, 1'b0);
    full_write(6'd5, 12'h123);
    read_check("t3_rd5", 6'd5, 12'h123);

    // overrun keeps the last 18 bits
    sclk_bit(1'b1);
    full_write(6'd3, 12'h555);
    check("t4_frame_err", bus.frame_err, 1'b1);
    read_check("t4_rd3", 6'd3, 12'h555);
    clear_err();

    // reset mid-word with SCLK held high through release
    shift_bits({6'd7, 12'h3C3}, 9);
    bus.SCLK = 1'b1;
    do_reset();
    wait_cyc(10);
    check("t5_shout", bus.SHOUT, 1'b0);
    check("t5_load_count", bus.load_count, 8'd0);
    check("t5_frame_err", bus.frame_err, 1'b0);
    check("t5_wr_addr", bus.wr_addr, 6'd0);
    check("t5_wr_data", bus.wr_data, 12'd0);
    bus.SCLK = 1'b0;
    wait_cyc(4);
    full_write(6'd2, 12'h0F0);
    check("t5_load_one", bus.load_count, 8'd1);
    read_check("t5_rd2", 6'd2, 12'h0F0);
    read_check("t5_rd0_cleared", 6'd0, 12'h000);

    // full programmer sequence
    do_reset();
    wait_cyc(4);
    for (int a = 0; a < 46; a++) full_write(6'(a), 12'($urandom));
    full_write(6'd61, 12'hFFF);
    check("t6_load_count", bus.load_count, 8'd47);
    for (int a = 0; a < 64; a++) read_check("t6_regs", 6'(a), mregs[a]);

    // random mix of well-formed and malformed sequences
    for (int it = 0; it < 24; it++) begin
      logic [17:0] w;
      w = 18'($urandom);
      case ($urandom_range(0, 4))
        0: full_write(w[17:12], w[11:0]);
        1: begin shift_bits(w, 18); pclk_pulse(1'b0); pclk_pulse(1'b0); pclk_pulse(1'b1); settle(); end
        2: begin pclk_pulse(1'b1); settle(); clear_err(); end
        3: begin
             shift_bits(w, 18); pclk_pulse(1'b0);
             full_write(6'($urandom), 12'($urandom));
             clear_err();
           end
        default: begin shift_bits(w, $urandom_range(16, 19)); pclk_pulse(1'b0); pclk_pulse(1'b1); settle(); clear_err(); end
      endcase
    end
    settle();
    for (int a = 0; a < 64; a++) read_check("final_regs", 6'(a), mregs[a]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
